// File: rtl/cpu_pkg.sv
// Shared core constants: register address width, src1 operand modes and src1 mux select codes.
package cpu_pkg;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [SEL_W-1:0] SEL_P1   = 3'b000;
  localparam logic [SEL_W-1:0] SEL_IMM4 = 3'b001;
  localparam logic [SEL_W-1:0] SEL_IMM8 = 3'b010;
  localparam logic [SEL_W-1:0] SEL_PC   = 3'b011;
  localparam logic [SEL_W-1:0] SEL_MEM  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_EX   = 3'b110;

  localparam logic [MODE_W-1:0] MODE_REG  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_IMM4 = 2'b01;
  localparam logic [MODE_W-1:0] MODE_IMM8 = 2'b10;
  localparam logic [MODE_W-1:0] MODE_PC   = 2'b11;

  // Non-forwarded select code for a given operand mode.
  function automatic logic [SEL_W-1:0] mode_sel(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_IMM4: mode_sel = SEL_IMM4;
      MODE_IMM8: mode_sel = SEL_IMM8;
      MODE_PC:   mode_sel = SEL_PC;
      default:   mode_sel = SEL_P1;
    endcase
  endfunction
endpackage

// File: rtl/fwd_hit_cmp.sv
// Producer/consumer match for one pipeline stage; R0 is hard-wired zero and never matches.
module fwd_hit_cmp
  import cpu_pkg::*;
(
  input  logic              stage_v,
  input  logic              stage_we,
  input  logic [REG_AW-1:0] stage_dst,
  input  logic              rd_en,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              hit_c
);
  assign hit_c = rd_en && stage_v && stage_we && (stage_dst == rd_addr)
                 && (rd_addr != REG_AW'(0));
endmodule

// File: rtl/src1_fwd_ctrl.sv
// EX-stage src1 forwarding and load-use hazard controller.
// Define SRC1_FWD_PERF_EN to add saturating forward/stall event counters.
module src1_fwd_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_src1_mode,
  input  logic [REG_AW-1:0] id_src1_addr,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              hold_in,
  input  logic              flush,
`ifdef SRC1_FWD_PERF_EN
  output logic [15:0]       fwd_ex_cnt,
  output logic [15:0]       fwd_mem_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic [2:0]        src1sel,
  output logic              stall_id,
  output logic              bubble_ex
);
  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_dst;
  logic              mem_v, mem_we;
  logic [REG_AW-1:0] mem_dst;

  logic              rd_en;
  logic              hit_e, hit_m;
  logic              load_use;
  logic [SEL_W-1:0]  sel_c;

  assign rd_en = id_valid && (id_src1_mode == MODE_REG);

  fwd_hit_cmp u_hit_ex (
    .stage_v   (ex_v),
    .stage_we  (ex_we),
    .stage_dst (ex_dst),
    .rd_en     (rd_en),
    .rd_addr   (id_src1_addr),
    .hit_c     (hit_e)
  );

  fwd_hit_cmp u_hit_mem (
    .stage_v   (mem_v),
    .stage_we  (mem_we),
    .stage_dst (mem_dst),
    .rd_en     (rd_en),
    .rd_addr   (id_src1_addr),
    .hit_c     (hit_m)
  );

  // Newer producer (EX) wins over MEM.
  always_comb begin
    sel_c = mode_sel(id_src1_mode);
    if (hit_e)      sel_c = SEL_EX;
    else if (hit_m) sel_c = SEL_MEM;
  end

  assign load_use = hit_e && ex_ld;
  // Freeze and redirect both override the load-use stall.
  assign stall_id = load_use && !hold_in && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_dst    <= '0;
      mem_v     <= 1'b0;
      mem_we    <= 1'b0;
      mem_dst   <= '0;
      src1sel   <= SEL_P1;
      bubble_ex <= 1'b0;
    end else if (!hold_in) begin
      mem_v   <= ex_v;
      mem_we  <= ex_we;
      mem_dst <= ex_dst;
      ex_we   <= id_we;
      ex_ld   <= id_is_load;
      ex_dst  <= id_dst_addr;
      if (flush || load_use) begin
        ex_v      <= 1'b0;
        src1sel   <= SEL_P1;
        bubble_ex <= 1'b1;
      end else begin
        ex_v      <= id_valid;
        src1sel   <= sel_c;
        bubble_ex <= 1'b0;
      end
    end
  end

`ifdef SRC1_FWD_PERF_EN
  logic inc_ex, inc_mem;
  assign inc_ex  = !flush && !load_use && (sel_c == SEL_EX);
  assign inc_mem = !flush && !load_use && (sel_c == SEL_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_ex_cnt  <= '0;
      fwd_mem_cnt <= '0;
      stall_cnt   <= '0;
    end else if (!hold_in) begin
      if (inc_ex && fwd_ex_cnt != 16'hFFFF)   fwd_ex_cnt  <= fwd_ex_cnt + 16'd1;
      if (inc_mem && fwd_mem_cnt != 16'hFFFF) fwd_mem_cnt <= fwd_mem_cnt + 16'd1;
      if (stall_id && stall_cnt != 16'hFFFF)  stall_cnt   <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_src1_fwd_ctrl.sv
// Self-checking bench for src1_fwd_ctrl: cycle vector table with a src1sel/bubble scoreboard.
module tb_src1_fwd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_src1_mode;
  logic [3:0] id_src1_addr;
  logic [3:0] id_dst_addr;
  logic       id_we;
  logic       id_is_load;
  logic       hold_in;
  logic       flush;
  logic [2:0] src1sel;
  logic       stall_id;
  logic       bubble_ex;
`ifdef SRC1_FWD_PERF_EN
  logic [15:0] fwd_ex_cnt, fwd_mem_cnt, stall_cnt;
`endif

  src1_fwd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1_mode (id_src1_mode),
    .id_src1_addr (id_src1_addr),
    .id_dst_addr  (id_dst_addr),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .hold_in      (hold_in),
    .flush        (flush),
`ifdef SRC1_FWD_PERF_EN
    .fwd_ex_cnt   (fwd_ex_cnt),
    .fwd_mem_cnt  (fwd_mem_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .src1sel      (src1sel),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] mode;
    logic [3:0] s1;
    logic [3:0] dst;
    logic       we;
    logic       ld;
    logic       hold;
    logic       fl;
    logic       e_stall;
    logic [2:0] e_sel;
    logic       e_bub;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic       bub;
    int         idx;
  } exp_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int v, input int mode, input int s1, input int dst,
                              input int we, input int ld, input int hold, input int fl,
                              input int st, input int sel, input int bub);
    vec_t t;
    t.v = 1'(v);        t.mode = 2'(mode);  t.s1 = 4'(s1);     t.dst = 4'(dst);
    t.we = 1'(we);      t.ld = 1'(ld);      t.hold = 1'(hold); t.fl = 1'(fl);
    t.e_stall = 1'(st); t.e_sel = 3'(sel);  t.e_bub = 1'(bub);
    return t;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v;   id_src1_mode = t.mode; id_src1_addr = t.s1; id_dst_addr = t.dst;
    id_we = t.we;     id_is_load = t.ld;     hold_in = t.hold;    flush = t.fl;
  endtask

  // Drive one ID-stage cycle, check the same-cycle stall, score the registered outputs after the edge.
  task automatic apply(input vec_t t, input int idx);
    exp_t e, got;
    @(negedge clk);
    drive(t);
    #1;
    check("stall_id", idx, int'(stall_id), int'(t.e_stall));
    e.sel = t.e_sel; e.bub = t.e_bub; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", idx, 0, 1);
    end else begin
      got = sb.pop_front();
      check("src1sel", got.idx, int'(src1sel), int'(got.sel));
      check("bubble_ex", got.idx, int'(bubble_ex), int'(got.bub));
    end
  endtask

  initial begin
    //               v mode s1 dst we ld hold fl | stall sel bub
    vecs[0]  = mk(1, 0,  1,  3, 1, 0, 0, 0,   0, 3'b000, 0); // ADD R3
    vecs[1]  = mk(1, 0,  3,  4, 1, 0, 0, 0,   0, 3'b110, 0); // use R3 back-to-back
    vecs[2]  = mk(1, 0,  7,  6, 1, 0, 0, 0,   0, 3'b000, 0); // unrelated
    vecs[3]  = mk(1, 0,  4,  8, 1, 0, 0, 0,   0, 3'b100, 0); // use R4 two ahead
    vecs[4]  = mk(1, 0,  1,  9, 1, 0, 0, 0,   0, 3'b000, 0); // ADD R9
    vecs[5]  = mk(1, 0,  2,  9, 1, 0, 0, 0,   0, 3'b000, 0); // ADD R9 again
    vecs[6]  = mk(1, 0,  9, 10, 1, 0, 0, 0,   0, 3'b110, 0); // EX beats MEM
    vecs[7]  = mk(1, 0,  0,  0, 1, 0, 0, 0,   0, 3'b000, 0); // write R0
    vecs[8]  = mk(1, 0,  0, 11, 1, 0, 0, 0,   0, 3'b000, 0); // read R0
    vecs[9]  = mk(1, 3, 11, 12, 1, 0, 0, 0,   0, 3'b011, 0); // pc mode despite hitE
    vecs[10] = mk(1, 1, 11, 13, 1, 0, 0, 0,   0, 3'b001, 0); // imm4 despite hitM
    vecs[11] = mk(1, 2, 13,  5, 1, 1, 0, 0,   0, 3'b010, 0); // LW R5, imm8
    vecs[12] = mk(1, 0,  5, 14, 1, 0, 0, 0,   1, 3'b000, 1); // load-use stall
    vecs[13] = mk(1, 0,  5, 14, 1, 0, 0, 0,   0, 3'b100, 0); // replay -> MEM
    vecs[14] = mk(1, 0,  1,  6, 1, 1, 0, 0,   0, 3'b000, 0); // LW R6
    vecs[15] = mk(1, 0,  6,  7, 1, 0, 0, 1,   0, 3'b000, 1); // load-use + flush
    vecs[16] = mk(1, 0,  6,  7, 1, 0, 0, 0,   0, 3'b100, 0); // load now in MEM
    vecs[17] = mk(1, 0,  1,  2, 1, 1, 0, 0,   0, 3'b000, 0); // LW R2
    vecs[18] = mk(1, 0,  2, 15, 1, 0, 1, 0,   0, 3'b000, 0); // hold masks stall
    vecs[19] = mk(1, 0,  2, 15, 1, 0, 0, 0,   1, 3'b000, 1); // stall
    vecs[20] = mk(1, 0,  2, 15, 1, 0, 1, 0,   0, 3'b000, 1); // hold during stall: frozen
    vecs[21] = mk(1, 0,  2, 15, 1, 0, 0, 0,   0, 3'b100, 0); // resume -> MEM
    vecs[22] = mk(0, 0, 15,  1, 1, 0, 0, 0,   0, 3'b000, 0); // invalid ID, no forward
    vecs[23] = mk(1, 0, 15,  1, 0, 0, 0, 0,   0, 3'b100, 0); // R15 in MEM; dst no-write
    vecs[24] = mk(1, 0,  1,  0, 0, 0, 0, 0,   0, 3'b000, 0); // EX has we=0 -> no hit

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_src1sel", -1, int'(src1sel), 0);
    check("rst_stall_id", -1, int'(stall_id), 0);
    check("rst_bubble_ex", -1, int'(bubble_ex), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

`ifdef SRC1_FWD_PERF_EN
    check("fwd_ex_cnt", -1, int'(fwd_ex_cnt), 2);
    check("fwd_mem_cnt", -1, int'(fwd_mem_cnt), 5);
    check("stall_cnt", -1, int'(stall_cnt), 2);
`endif

    // Reset asserted while a load-use stall is showing.
    apply(mk(1, 0, 1, 5, 1, 1, 0, 0, 0, 3'b000, 0), 100);
    @(negedge clk);
    drive(mk(1, 0, 5, 9, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("midstall_stall_id", 101, int'(stall_id), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_src1sel", 102, int'(src1sel), 0);
    check("post_rst_stall_id", 102, int'(stall_id), 0);
    check("post_rst_bubble_ex", 102, int'(bubble_ex), 0);
`ifdef SRC1_FWD_PERF_EN
    check("post_rst_fwd_ex_cnt", 102, int'(fwd_ex_cnt), 0);
    check("post_rst_fwd_mem_cnt", 102, int'(fwd_mem_cnt), 0);
    check("post_rst_stall_cnt", 102, int'(stall_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    // Same consumer after reset: no producer tracked, so no stall and plain reg select.
    apply(mk(1, 0, 5, 9, 1, 0, 0, 0, 0, 3'b000, 0), 103);

    check("scoreboard_drained", -1, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
